// File: rtl/if_prefetch_pkg.sv
// Shared constants and width helpers for the instruction-fetch prefetch stage.
package if_prefetch_pkg;

  localparam int          AW_DEF       = 32;
  localparam int          INST_W       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'hbfc0_0000;

  // Width of the packed {br_e, br_addr} redirect bus.
  function automatic int br_wd(input int aw);
    return 1 + aw;
  endfunction

  // Width of the packed {id_pc, id_inst} pair handed to ID.
  function automatic int if_to_id_wd(input int aw);
    return aw + INST_W;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO used as the prefetch queue; head is read straight
// from registered storage, so a pushed entry is visible the cycle after push.
module if_fifo
  import if_prefetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] entries [DEPTH];

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;
      logic             wr_sel;

      assign wr_sel = do_push && (wr_ptr_reg == PW'(gi));

      always_ff @(posedge clk) begin
        if (wr_sel) entry_reg <= din;
      end

      assign entries[gi] = entry_reg;
    end
  endgenerate

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (do_push) wr_ptr_next = wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
      count_next = count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign count = count_reg;
  // Storage is unreset, so present zeros whenever nothing valid is held.
  assign dout  = empty ? '0 : entries[rd_ptr_reg];

endmodule

// File: rtl/if_prefetch.sv
// Fetch stage: issues PCs to the instruction SRAM under a queue-credit check
// and buffers {pc, inst} pairs for ID; a redirect flushes and drops in-flight data.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int            AW       = AW_DEF,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          br_e,
  input  logic [AW-1:0] br_addr,
  output logic          inst_sram_en,
  output logic [3:0]    inst_sram_wen,
  output logic [AW-1:0] inst_sram_addr,
  output logic [31:0]   inst_sram_wdata,
  input  logic [31:0]   inst_sram_rdata,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [AW-1:0] id_pc,
  output logic [31:0]   id_inst
);

  localparam int BR_WD       = br_wd(AW);
  localparam int IF_TO_ID_WD = if_to_id_wd(AW);
  localparam int CW          = $clog2(DEPTH) + 1;

  logic [BR_WD-1:0]       br_bus;
  logic                   br_taken;
  logic [AW-1:0]          br_target;

  logic                   run_reg;
  logic [AW-1:0]          fetch_pc_reg, fetch_pc_next;
  logic [AW-1:0]          req_pc_reg, req_pc_next;
  logic                   inflight_reg, inflight_next;
  logic                   drop_reg, drop_next;

  logic                   push, pop, full, empty;
  logic [CW-1:0]          count;
  logic [CW:0]            used;
  logic                   credit, issue;
  logic [IF_TO_ID_WD-1:0] fifo_din, fifo_dout;

  assign br_bus    = {br_e, br_addr};
  assign br_taken  = br_bus[BR_WD-1];
  assign br_target = br_bus[AW-1:0];

  // An outstanding request has a reserved slot, so count+inflight bounds occupancy.
  always_comb begin
    used          = {1'b0, count} + (CW+1)'(inflight_reg);
    credit        = used < (CW+1)'(DEPTH);
    issue         = run_reg & credit & ~br_taken;
    fetch_pc_next = fetch_pc_reg;
    req_pc_next   = req_pc_reg;
    if (br_taken) begin
      fetch_pc_next = br_target;
    end else if (issue) begin
      fetch_pc_next = fetch_pc_reg + AW'(4);
      req_pc_next   = fetch_pc_reg;
    end
    inflight_next = issue;
    drop_next     = br_taken & inflight_reg;
  end

  // run_reg holds off the first issue until one full cycle after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_reg      <= 1'b0;
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= '0;
      inflight_reg <= 1'b0;
      drop_reg     <= 1'b0;
    end else begin
      run_reg      <= 1'b1;
      fetch_pc_reg <= fetch_pc_next;
      req_pc_reg   <= req_pc_next;
      inflight_reg <= inflight_next;
      drop_reg     <= drop_next;
    end
  end

  assign push     = inflight_reg & ~drop_reg & ~br_taken;
  assign id_valid = ~empty & ~br_taken;
  assign pop      = id_valid & id_ready;
  assign fifo_din = {req_pc_reg, inst_sram_rdata};

  if_fifo #(
    .WIDTH (IF_TO_ID_WD),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .flush (br_taken),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign id_pc           = fifo_dout[IF_TO_ID_WD-1:32];
  assign id_inst         = fifo_dout[31:0];
  assign inst_sram_en    = issue;
  assign inst_sram_addr  = fetch_pc_reg;
  assign inst_sram_wen   = 4'b0;
  assign inst_sram_wdata = 32'b0;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
- Parametrised successor to the single-PC fetch stage: generates fetch PCs, drives the instruction SRAM and buffers returned instructions in a DEPTH-entry prefetch queue.
- ID consumes {pc, inst} pairs through a valid/ready handshake, so back-pressure is decoupled from fetch.
- A branch redirect flushes the queue and discards any in-flight response.
- Sits between the instruction SRAM and ID.

Parameters:
AW, 32, PC/address width.
DEPTH, 4, prefetch queue entries (power of two, >=2).
RESET_PC, 32'hbfc0_0000, first PC fetched after reset.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
br_e  in  1  branch redirect strobe from EX
br_addr  in  AW  redirect target
inst_sram_en  out  1  read request this cycle
inst_sram_wen  out  4  tied 4'b0
inst_sram_addr  out  AW  fetch PC
inst_sram_wdata  out  32  tied 32'b0
inst_sram_rdata  in  32  read data, valid exactly 1 cycle after an en=1 cycle
id_valid  out  1  queue head valid
id_ready  in  1  ID accepts head
id_pc  out  AW  head PC
id_inst  out  32  head instruction

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC, queue empty, inflight=0, drop=0. Outputs: inst_sram_en=0, id_valid=0, id_pc=0, id_inst=0.
- Issue rule, evaluated combinationally:
  - inst_sram_en=1 when (count + inflight) < DEPTH and br_e=0; inst_sram_addr=fetch_pc.
  - On issue: fetch_pc += 4 (wraps modulo 2^AW), inflight<=1, req_pc<=fetch_pc.
  - With no issue, inflight<=0.
- Response: in the cycle after an issue (inflight=1), {req_pc, inst_sram_rdata} is pushed into the queue unless drop=1 or br_e=1.
- ID handshake:
  - Pop when id_valid & id_ready.
  - id_valid = !empty & !br_e (masked in the redirect cycle).
  - Queue output is registered; there is no bypass. The first instruction after reset appears 2 cycles after its issue.
- Redirect (br_e=1):
  - No issue this cycle; next cycle fetch_pc=br_addr.
  - Queue cleared; no pop occurs.
  - drop<=inflight, which discards a response landing next cycle. drop clears after one cycle.
  - If issue resumes in the cycle after br_e, that response is kept: the drop applies only to the pre-redirect request.
- Back-to-back br_e: the last one wins; the queue stays empty.
- Simultaneous push and pop: count unchanged, FIFO order preserved.
- Full: the credit check (count + inflight) < DEPTH guarantees no push into a full queue. A push when full is an assertion failure.
- Empty: id_valid=0; id_ready is ignored.
- Latency from reset release: issue at cycle 1 (addr=RESET_PC), push at cycle 2, id_valid=1 with id_pc=RESET_PC at cycle 3.
- Steady-state throughput with id_ready=1: 1 instruction/cycle.

Decomposition:
- Shared package/defines: RESET_PC default, BR_WD (=1+AW) for packing {br_e, br_addr}, and IF_TO_ID_WD (=AW+32) for {id_pc, id_inst}.
- One natural sub-module, if_fifo: a synchronous FIFO with parameters WIDTH and DEPTH and ports push, pop, flush, full, empty, count. Same async active-low reset.
- if_prefetch contains the PC/credit/drop logic and instantiates if_fifo.

Test Plan:
- Reset release, id_ready=1, SRAM model returns rdata=addr:
  - Expect en=1 with addr=bfc00000 at cycle 1.
  - Expect id_valid at cycle 3 with pc=bfc00000, inst=bfc00000.
  - Then one pair per cycle: bfc00004, bfc00008, ...
- id_ready=0, DEPTH=4:
  - Exactly 4 issues (…000 to …00c), then en=0 held.
  - Raise id_ready: pops in order …000, …004, …; issue resumes at …010 one cycle after the first pop.
- br_e=1 with br_addr=bfc00100 while queue holds 3 entries and a request is in flight:
  - id_valid=0 that cycle.
  - Next cycle queue empty; the stale response is not pushed; en=1 with addr=bfc00100.
  - First delivered pc=bfc00100.
- br_e on two consecutive cycles (targets 200, then 300):
  - Only 300, 304, ... are delivered; nothing from 200.
- Assert rst=0 mid-operation with a full queue and an in-flight request:
  - Immediately (asynchronously) en=0, id_valid=0.
  - After release, fetch restarts at bfc00000.
- Wrap-around: br_addr=ffff_fffc:
  - Delivered pcs are ffff_fffc, then 0000_0000, then 0000_0004.
